// File: rtl/v_hier_qpipe.sv
// Single-clock FIFO with a one-cycle push-to-head latency and an optional
// running-XOR encoding of stored words (MODE 1).
module v_hier_qpipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int MODE  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         avec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         qvec,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] store_word;
  logic             push;
  logic             pop;

  logic [WIDTH-1:0] mem [DEPTH];

  // Handshake flags come only from the registered count, so in_ready never
  // depends on out_ready and there is no avec->qvec combinational path.
  assign in_ready  = (count_reg != CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign count     = count_reg;

  // clr wins over both handshakes in the same cycle.
  assign push = in_valid & in_ready & ~clr;
  assign pop  = out_valid & out_ready & ~clr;

  assign qvec = out_valid ? mem[rd_ptr_reg] : '0;

  generate
    if (MODE == 1) begin : g_xor_acc
      logic [WIDTH-1:0] acc_reg;
      logic [WIDTH-1:0] acc_next;

      assign store_word = avec ^ acc_reg;

      always_comb begin
        acc_next = acc_reg;
        if (clr) begin
          acc_next = '0;
        end else if (push) begin
          acc_next = store_word;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc_reg <= '0;
        end else begin
          acc_reg <= acc_next;
        end
      end
    end else begin : g_pass
      assign store_word = avec;
    end
  endgenerate

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (clr) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is deliberately outside the reset domain; flush and reset only
  // move the pointers, so stale words are simply unreachable.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr_reg] <= store_word;
    end
  end

endmodule

// File: tb/tb_v_hier_qpipe.sv
// Scoreboard bench: one MODE 0 and one MODE 1 instance share stimulus; a
// queue model predicts contents and a negedge monitor compares.
module tb_v_hier_qpipe;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] avec = '0;

  logic             in_ready0, out_valid0, in_ready1, out_valid1;
  logic [WIDTH-1:0] qvec0, qvec1;
  logic [CW-1:0]    count0, count1;

  v_hier_qpipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
    .avec(avec), .out_valid(out_valid0), .out_ready(out_ready), .qvec(qvec0),
    .count(count0)
  );

  v_hier_qpipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
    .avec(avec), .out_valid(out_valid1), .out_ready(out_ready), .qvec(qvec1),
    .count(count1)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] sb0[$];
  logic [WIDTH-1:0] sb1[$];
  logic [WIDTH-1:0] acc_m = '0;
  int               n_checks = 0;
  int               n_pass = 0;
  bit               mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] sz;
    sz = 64'(sb0.size());
    check({tag, " count0"},     64'(count0),     sz);
    check({tag, " count1"},     64'(count1),     sz);
    check({tag, " out_valid0"}, 64'(out_valid0), 64'(sz != 0));
    check({tag, " out_valid1"}, 64'(out_valid1), 64'(sz != 0));
    check({tag, " in_ready0"},  64'(in_ready0),  64'(sz != DEPTH));
    check({tag, " in_ready1"},  64'(in_ready1),  64'(sz != DEPTH));
    check({tag, " qvec0"},      64'(qvec0), (sz != 0) ? 64'(sb0[0]) : 64'd0);
    check({tag, " qvec1"},      64'(qvec1), (sz != 0) ? 64'(sb1[0]) : 64'd0);
  endtask

  // Monitor: outputs settle long before the falling edge; a pop predicted
  // here happens at the following rising edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check_outputs("mon");
      if (out_ready && !clr && sb0.size() != 0) begin
        $display("pop  mode0=0x%0h mode1=0x%0h", sb0[0], sb1[0]);
        void'(sb0.pop_front());
        void'(sb1.pop_front());
      end
    end
  end

  // One clock of stimulus; the model records what the next edge accepts.
  task automatic cycle(input bit iv, input logic [WIDTH-1:0] a, input bit ordy, input bit c);
    bit               will_push;
    logic [WIDTH-1:0] enc;
    in_valid  = iv;
    avec      = a;
    out_ready = ordy;
    clr       = c;
    will_push = iv && !c && (sb0.size() < DEPTH);
    enc       = a ^ acc_m;
    @(posedge clk);
    if (c) begin
      sb0.delete();
      sb1.delete();
      acc_m = '0;
      $display("clr");
    end else if (will_push) begin
      sb0.push_back(a);
      sb1.push_back(enc);
      acc_m = enc;
      $display("push avec=0x%0h mode1_word=0x%0h", a, enc);
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic rst_pulse();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
    #2 rst = 1'b1;
    sb0.delete();
    sb1.delete();
    acc_m = '0;
    #1 check_outputs("rst_async");
    $display("rst pulse");
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #2 check_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // In-order pass-through, then drain to empty.
    cycle(1, 4'h3, 0, 0);
    cycle(1, 4'h5, 0, 0);
    cycle(1, 4'h9, 0, 0);
    cycle(0, 4'h0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 4'h0, 1, 0);
    cycle(0, 4'h0, 0, 0);
    cycle(0, 4'h0, 0, 1);

    // Running-XOR words 3,5,6 encode to 3,6,0.
    cycle(1, 4'h3, 0, 0);
    cycle(1, 4'h5, 0, 0);
    cycle(1, 4'h6, 0, 0);
    drain();

    // Overfill: fifth word refused.
    for (int i = 1; i <= 5; i++) cycle(1, WIDTH'(i), 0, 0);
    drain();

    // Full with push+pop: only pop; then push+pop with count held.
    for (int i = 1; i <= 4; i++) cycle(1, WIDTH'(i), 0, 0);
    cycle(1, 4'h7, 1, 0);
    cycle(1, 4'h8, 1, 0);
    cycle(0, 4'h0, 0, 0);
    drain();

    // Flush beats a concurrent push.
    cycle(1, 4'hA, 0, 0);
    cycle(1, 4'hB, 0, 0);
    cycle(1, 4'hC, 0, 1);
    cycle(0, 4'h0, 0, 0);
    cycle(1, 4'hD, 0, 0);
    drain();

    // Reset mid-stream, then resume as if empty.
    cycle(1, 4'h1, 0, 0);
    cycle(1, 4'h2, 0, 0);
    rst_pulse();
    cycle(1, 4'hE, 0, 0);
    cycle(1, 4'h4, 1, 0);
    drain();

    // Randomized phases with shifting push/pop bias and rare flushes.
    for (int ph = 0; ph < 4; ph++) begin
      int pv;
      int pr;
      pv = (ph == 0) ? 80 : (ph == 1) ? 30 : 60;
      pr = (ph == 0) ? 30 : (ph == 1) ? 80 : 60;
      for (int i = 0; i < 120; i++) begin
        cycle($urandom_range(0, 99) < pv, WIDTH'($urandom), $urandom_range(0, 99) < pr,
              $urandom_range(0, 49) == 0);
      end
      if (ph == 2) rst_pulse();
    end
    drain();

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
